// File: rtl/prvp_spi_slave_core.sv
// -----------------------------------------------------------------------------
// prvp_spi_slave_core
//
// Oversampled SPI slave engine, mode 0 (CPOL=0, CPHA=0), MSB first. All SPI
// pins are brought into the clk_i domain through 2-flop synchronisers plus a
// history flop, so spi_sclk_i is only ever sampled, never used as a clock.
// MOSI is deserialised into a valid/ready RX word stream and a valid/ready TX
// word stream is serialised onto MISO.
//
// Ports:
//   clk_i          system clock (>= 8x SCLK)
//   rst_ni         asynchronous active-low reset
//   clr_i          synchronous clear of state, shift registers and flags
//   spi_sclk_i     SPI clock from master
//   spi_cs_ni      chip select, active-low
//   spi_mosi_i     master-out data
//   spi_miso_o     slave-out data (0 when not driven)
//   spi_miso_oe_o  MISO output enable, high while selected
//   rx_data_o      received word
//   rx_valid_o     rx_data_o valid
//   rx_ready_i     downstream accepts the RX word
//   tx_data_i      next word to transmit
//   tx_valid_i     tx_data_i valid
//   tx_ready_o     one-cycle pop strobe for the TX word
//   overflow_o     sticky: an RX word was dropped
//   underrun_o     sticky: TX_IDLE was sent for lack of a TX word
//   busy_o         transfer in progress
// -----------------------------------------------------------------------------
module prvp_spi_slave_core #(
   parameter int unsigned              DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0]    TX_IDLE    = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  spi_sclk_i,
   input  logic                  spi_cs_ni,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic                  spi_miso_oe_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  overflow_o,
   output logic                  underrun_o,
   output logic                  busy_o
);

   localparam int unsigned          CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_e;

   // Synchronisers: stage 1, stage 2, history
   logic sclk_s1_q, sclk_s2_q, sclk_h_q;
   logic cs_s1_q,   cs_s2_q,   cs_h_q;
   logic mosi_s1_q, mosi_s2_q;

   // Counts cycles since reset release until the history flops hold real pin
   // samples. Until then the reset value cs_n=1 in the chain would fake a CS
   // fall if the pin is already low.
   logic [1:0] fill_q;
   logic       sync_ok;

   logic sclk_rise, sclk_fall, cs_fall, cs_rise;

   state_e                state_q,    state_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
   logic                  done_q,     done_d;      // a word completed in this CS window
   logic [DATA_WIDTH-1:0] rx_data_q,  rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  ovf_q,      ovf_d;
   logic                  udr_q,      udr_d;
   logic [DATA_WIDTH-1:0] rx_word;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_h_q  <= 1'b0;
         cs_s1_q   <= 1'b1;
         cs_s2_q   <= 1'b1;
         cs_h_q    <= 1'b1;
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
         fill_q    <= 2'd0;
      end else begin
         sclk_s1_q <= spi_sclk_i;
         sclk_s2_q <= sclk_s1_q;
         sclk_h_q  <= sclk_s2_q;
         cs_s1_q   <= spi_cs_ni;
         cs_s2_q   <= cs_s1_q;
         cs_h_q    <= cs_s2_q;
         mosi_s1_q <= spi_mosi_i;
         mosi_s2_q <= mosi_s1_q;
         if (fill_q != 2'd3) begin
            fill_q <= fill_q + 2'd1;
         end
      end
   end

   assign sync_ok   = (fill_q == 2'd3);
   assign sclk_rise =  sclk_s2_q & ~sclk_h_q;
   assign sclk_fall = ~sclk_s2_q &  sclk_h_q;
   assign cs_fall   = sync_ok & ~cs_s2_q & cs_h_q;
   assign cs_rise   =  cs_s2_q & ~cs_h_q;

   assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s2_q};

   always_comb begin
      state_d    = state_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = done_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      ovf_d      = ovf_q;
      udr_d      = udr_q;
      tx_ready_o = 1'b0;

      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d = ST_LOAD;
            end
         end

         ST_LOAD: begin
            tx_ready_o = 1'b1;
            tx_shift_d = tx_valid_i ? tx_data_i : TX_IDLE;
            if (!tx_valid_i) begin
               udr_d = 1'b1;
            end
            bit_cnt_d = '0;
            done_d    = 1'b0;
            state_d   = cs_rise ? ST_IDLE : ST_ACTIVE;
         end

         ST_ACTIVE: begin
            if (cs_rise) begin
               // Partial word dropped; the TX word already loaded is not replayed.
               state_d    = ST_IDLE;
               bit_cnt_d  = '0;
               rx_shift_d = '0;
               done_d     = 1'b0;
            end else if (sclk_rise) begin
               rx_shift_d = rx_word;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  if (!rx_valid_q || rx_ready_i) begin
                     rx_data_d  = rx_word;
                     rx_valid_d = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sclk_fall) begin
               // The fall after a completed word puts the next word's MSB out.
               if (bit_cnt_q == '0 && done_q) begin
                  tx_ready_o = 1'b1;
                  tx_shift_d = tx_valid_i ? tx_data_i : TX_IDLE;
                  if (!tx_valid_i) begin
                     udr_d = 1'b1;
                  end
               end else begin
                  tx_shift_d = tx_shift_q << 1;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clr_i) begin
         state_d    = ST_IDLE;
         tx_shift_d = '0;
         rx_shift_d = '0;
         bit_cnt_d  = '0;
         done_d     = 1'b0;
         rx_data_d  = '0;
         rx_valid_d = 1'b0;
         ovf_d      = 1'b0;
         udr_d      = 1'b0;
         tx_ready_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         bit_cnt_q  <= '0;
         done_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         done_q     <= done_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         ovf_q      <= ovf_d;
         udr_q      <= udr_d;
      end
   end

   assign busy_o        = (state_q != ST_IDLE);
   assign spi_miso_oe_o = busy_o;
   assign spi_miso_o    = busy_o & tx_shift_q[DATA_WIDTH-1];
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign overflow_o    = ovf_q;
   assign underrun_o    = udr_q;

endmodule

// File: tb/tb_prvp_spi_slave_core.sv
module tb_prvp_spi_slave_core;

   localparam int HALF = 8;   // clk cycles per SCLK half period

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       clr_i = 1'b0;
   logic       spi_sclk_i = 1'b0;
   logic       spi_cs_ni = 1'b1;
   logic       spi_mosi_i = 1'b0;
   logic       rx_ready_i = 1'b0;
   logic [7:0] tx_data_i = 8'h00;
   logic       tx_valid_i = 1'b0;

   logic       spi_miso_o, spi_miso_oe_o, rx_valid_o, tx_ready_o;
   logic       overflow_o, underrun_o, busy_o;
   logic [7:0] rx_data_o;
   logic [6:0] outs;

   prvp_spi_slave_core #(
      .DATA_WIDTH (8),
      .TX_IDLE    (8'hFF)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .clr_i         (clr_i),
      .spi_sclk_i    (spi_sclk_i),
      .spi_cs_ni     (spi_cs_ni),
      .spi_mosi_i    (spi_mosi_i),
      .spi_miso_o    (spi_miso_o),
      .spi_miso_oe_o (spi_miso_oe_o),
      .rx_data_o     (rx_data_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .tx_data_i     (tx_data_i),
      .tx_valid_i    (tx_valid_i),
      .tx_ready_o    (tx_ready_o),
      .overflow_o    (overflow_o),
      .underrun_o    (underrun_o),
      .busy_o        (busy_o)
   );

   assign outs = {spi_miso_o, spi_miso_oe_o, rx_valid_o, tx_ready_o,
                  overflow_o, underrun_o, busy_o};

   always #5 clk_i = ~clk_i;

   int         checks = 0;
   int         errors = 0;
   int         strobes = 0;
   int         s0;
   logic [7:0] rx_exp_q[$];
   logic [7:0] miso_exp_q[$];
   logic [7:0] tx_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // TX source: presents the head of tx_q, pops it after a strobe that consumed it.
   logic consumed_last = 1'b0;
   always @(negedge clk_i) begin
      if (consumed_last && tx_q.size() > 0) tx_q.delete(0);
      if (tx_q.size() > 0) begin
         tx_valid_i = 1'b1;
         tx_data_i  = tx_q[0];
      end else begin
         tx_valid_i = 1'b0;
         tx_data_i  = 8'h00;
      end
      consumed_last = tx_ready_o && tx_valid_i;
      if (tx_ready_o) strobes++;
   end

   // RX monitor: every handshake must match the head of the expected queue.
   logic [7:0] rx_e;
   always @(negedge clk_i) begin
      #2;
      if (rx_valid_o && rx_ready_i) begin
         if (rx_exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: got 0x%0h expected no word", rx_data_o);
         end else begin
            rx_e = rx_exp_q.pop_front();
            chk("rx_word", {24'h0, rx_data_o}, {24'h0, rx_e});
         end
      end
   end

   // MISO monitor: master-side capture on SCLK rise, compared per full word.
   int         mbits = 0;
   logic [7:0] msh = 8'h00;
   logic [7:0] m_e;
   always @(posedge spi_sclk_i or posedge spi_cs_ni or negedge rst_ni) begin
      if (!rst_ni || spi_cs_ni) begin
         mbits = 0;
      end else begin
         msh = {msh[6:0], spi_miso_o};
         mbits++;
         if (mbits == 8) begin
            mbits = 0;
            if (miso_exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL miso_unexpected: got 0x%0h expected no word", msh);
            end else begin
               m_e = miso_exp_q.pop_front();
               chk("miso_word", {24'h0, msh}, {24'h0, m_e});
            end
         end
      end
   end

   // Master: nbits MSB first; with last=1 the final SCLK fall coincides with CS rise.
   task automatic send(input logic [7:0] w, input int nbits, input bit last, input bit rdy_pulse);
      for (int i = 0; i < nbits; i++) begin
         spi_mosi_i = w[7-i];
         wclk(HALF);
         spi_sclk_i = 1'b1;
         if (rdy_pulse && i == nbits - 1) begin
            // Lands on the cycle the DUT acts on this rise (3-cycle edge latency).
            wclk(2);
            rx_ready_i = 1'b1;
            wclk(1);
            rx_ready_i = 1'b0;
            wclk(HALF - 3);
         end else begin
            wclk(HALF);
         end
         spi_sclk_i = 1'b0;
         if (last && i == nbits - 1) spi_cs_ni = 1'b1;
      end
      wclk(HALF);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      wclk(3);
      chk("reset_outs", {25'h0, outs}, 32'h0);
      chk("reset_rx_data", {24'h0, rx_data_o}, 32'h0);
      rst_ni = 1'b1;
      wclk(6);

      // Single word
      tx_q.push_back(8'hA5); miso_exp_q.push_back(8'hA5); rx_exp_q.push_back(8'h3C);
      s0 = strobes;
      spi_cs_ni = 1'b0; wclk(4);
      chk("oe_selected", {31'h0, spi_miso_oe_o}, 32'h1);
      send(8'h3C, 8, 1, 0);
      chk("t1_strobes", strobes - s0, 1);
      chk("t1_rx_valid", {31'h0, rx_valid_o}, 32'h1);
      chk("t1_rx_data", {24'h0, rx_data_o}, 32'h3C);
      chk("t1_busy_after", {31'h0, busy_o}, 32'h0);
      rx_ready_i = 1'b1; wclk(1); rx_ready_i = 1'b0; wclk(1);
      chk("t1_rx_valid_cleared", {31'h0, rx_valid_o}, 32'h0);

      // Back-to-back words in one CS window
      rx_ready_i = 1'b1;
      tx_q.push_back(8'h81); tx_q.push_back(8'h42);
      miso_exp_q.push_back(8'h81); miso_exp_q.push_back(8'h42);
      rx_exp_q.push_back(8'h11); rx_exp_q.push_back(8'h22);
      s0 = strobes;
      spi_cs_ni = 1'b0; wclk(4);
      send(8'h11, 8, 0, 0);
      send(8'h22, 8, 1, 0);
      chk("t2_strobes", strobes - s0, 2);
      chk("t2_underrun", {31'h0, underrun_o}, 32'h0);

      // Underrun
      miso_exp_q.push_back(8'hFF); rx_exp_q.push_back(8'h5E);
      s0 = strobes;
      spi_cs_ni = 1'b0; wclk(4);
      send(8'h5E, 8, 1, 0);
      chk("t3_strobes", strobes - s0, 1);
      wclk(4);
      chk("t3_underrun_sticky", {31'h0, underrun_o}, 32'h1);
      clr_i = 1'b1; wclk(1); clr_i = 1'b0; wclk(1);
      chk("t3_underrun_clr", {31'h0, underrun_o}, 32'h0);

      // Overflow, then a completion in the same cycle as the ready
      rx_ready_i = 1'b0;
      tx_q.push_back(8'h00); tx_q.push_back(8'h0F); tx_q.push_back(8'hF0);
      miso_exp_q.push_back(8'h00); miso_exp_q.push_back(8'h0F); miso_exp_q.push_back(8'hF0);
      rx_exp_q.push_back(8'h01); rx_exp_q.push_back(8'h03);
      spi_cs_ni = 1'b0; wclk(4);
      send(8'h01, 8, 0, 0);
      chk("t4_no_ovf_yet", {31'h0, overflow_o}, 32'h0);
      send(8'h02, 8, 0, 0);
      chk("t4_ovf", {31'h0, overflow_o}, 32'h1);
      chk("t4_rx_held", {24'h0, rx_data_o}, 32'h01);
      send(8'h03, 8, 1, 1);
      chk("t4_rx_replaced", {24'h0, rx_data_o}, 32'h03);
      chk("t4_rx_valid_kept", {31'h0, rx_valid_o}, 32'h1);
      chk("t4_underrun", {31'h0, underrun_o}, 32'h0);
      rx_ready_i = 1'b1; wclk(1); rx_ready_i = 1'b0; wclk(1);
      chk("t4_rx_valid_cleared", {31'h0, rx_valid_o}, 32'h0);

      // CS abort mid-word
      rx_ready_i = 1'b1;
      tx_q.push_back(8'h77); tx_q.push_back(8'hC3);
      miso_exp_q.push_back(8'hC3); rx_exp_q.push_back(8'h5A);
      spi_cs_ni = 1'b0; wclk(4);
      send(8'hF0, 5, 1, 0);
      chk("t5_abort_outs", {29'h0, busy_o, spi_miso_oe_o, rx_valid_o}, 32'h0);
      spi_cs_ni = 1'b0; wclk(4);
      send(8'h5A, 8, 1, 0);
      chk("t5_busy_after", {31'h0, busy_o}, 32'h0);

      // Reset mid-word
      rx_ready_i = 1'b0;
      miso_exp_q.push_back(8'hFF);
      spi_cs_ni = 1'b0; wclk(4);
      send(8'hE7, 8, 1, 0);
      chk("t6_rx_pending", {31'h0, rx_valid_o}, 32'h1);
      chk("t6_rx_data", {24'h0, rx_data_o}, 32'hE7);
      spi_cs_ni = 1'b0; wclk(4);
      send(8'hB4, 4, 0, 0);
      rst_ni = 1'b0;
      #1;
      chk("t6_async_outs", {25'h0, outs}, 32'h0);
      chk("t6_async_rx_data", {24'h0, rx_data_o}, 32'h0);
      wclk(3);
      rst_ni = 1'b1;
      wclk(10);
      miso_exp_q.push_back(8'h00);
      send(8'hC6, 8, 0, 0);
      chk("t6_stale_cs_busy", {31'h0, busy_o}, 32'h0);
      chk("t6_stale_cs_rx", {31'h0, rx_valid_o}, 32'h0);
      spi_cs_ni = 1'b1; wclk(8);
      rx_ready_i = 1'b1;
      miso_exp_q.push_back(8'hFF); rx_exp_q.push_back(8'h96);
      spi_cs_ni = 1'b0; wclk(4);
      send(8'h96, 8, 1, 0);
      wclk(4);

      chk("rx_queue_drained", rx_exp_q.size(), 0);
      chk("miso_queue_drained", miso_exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
